// File: rtl/conv_maxpool_reader_if.sv
// Stream bundle for conv_maxpool_reader: frame control, input element stream,
// pooled output stream and status flags.
interface conv_maxpool_reader_if #(
    parameter int DATW = 10
);
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [DATW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DATW-1:0] out_data;
    logic            out_last;
    logic            busy;
    logic            done;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/conv_maxpool_reader.sv
// Streaming 2x2 / stride-2 max-pool over an FW x FW row-major frame.
// Define MAXPOOL_SIGNED_EN to compare elements as two's-complement signed.
module conv_maxpool_reader #(
    parameter int FW   = 3,
    parameter int DATW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_maxpool_reader_if.slave bus
);
    localparam int HW  = FW / 2;
    localparam int CW  = $clog2(FW);
    localparam int LW  = (HW > 1) ? $clog2(HW) : 1;
    localparam bit ODD = (FW % 2) != 0;
    localparam logic [CW-1:0] LAST_IDX = CW'(FW - 1);
    localparam logic [CW-1:0] POOL_END = CW'(2 * HW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col, row;
    logic [LW-1:0]   lb_idx;
    logic [DATW-1:0] held;
    logic [DATW-1:0] line_buf [HW];
    logic [DATW-1:0] pair_max, pool_max;
    logic [DATW-1:0] out_data_r;
    logic            out_valid_r, out_last_r;
    logic            in_ready_c, accept, in_pool, at_last, is_final;

    function automatic logic gt(input logic [DATW-1:0] a, input logic [DATW-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Output register may be refilled in the very cycle it is drained.
    assign in_ready_c = (state == S_RECV) && (!out_valid_r || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;

    // Floor pooling: the trailing column/row of an odd frame is swallowed.
    assign in_pool  = !(ODD && ((col == LAST_IDX) || (row == LAST_IDX)));
    assign at_last  = (col == LAST_IDX) && (row == LAST_IDX);
    assign is_final = (col == POOL_END) && (row == POOL_END);
    assign lb_idx   = LW'(col >> 1);

    assign pair_max = gt(bus.in_data, held) ? bus.in_data : held;
    assign pool_max = gt(pair_max, line_buf[lb_idx]) ? pair_max : line_buf[lb_idx];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RECV;
            S_RECV:  if (accept && at_last) state_nxt = S_DRAIN;
            S_DRAIN: if (!out_valid_r || bus.out_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state and every register below update with <= so all of them see
    // the same pre-edge values; = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if ((state == S_IDLE) && bus.start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (accept && in_pool && col[0] && row[0]) begin
            out_valid_r <= 1'b1;
            out_data_r  <= pool_max;
            out_last_r  <= is_final;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // NOTE: the pair register and line buffer carry no reset; each entry is
    // always rewritten before it is read, so a reset would only cost flops.
    always_ff @(posedge clk) begin
        if (accept && in_pool) begin
            if (!col[0]) begin
                held <= bus.in_data;
            end else if (!row[0]) begin
                line_buf[lb_idx] <= pair_max;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_conv_maxpool_reader.sv
// Scoreboard bench for conv_maxpool_reader: FW=4, FW=3 and FW=2 instances.
module tb_conv_maxpool_reader;
    localparam int DATW = 10;

    typedef struct packed {
        logic [DATW-1:0] data;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_maxpool_reader_if #(.DATW(DATW)) if4 ();
    conv_maxpool_reader_if #(.DATW(DATW)) if3 ();
    conv_maxpool_reader_if #(.DATW(DATW)) if2 ();

    conv_maxpool_reader #(.FW(4), .DATW(DATW)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    conv_maxpool_reader #(.FW(3), .DATW(DATW)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    conv_maxpool_reader #(.FW(2), .DATW(DATW)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int n_vec = 0;
    int n_err = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int done0 = 0, done1 = 0, done2 = 0;
    logic [DATW-1:0] stim[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitors: pop the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (if4.out_valid && if4.out_ready) begin
            if (q0.size() == 0) check("fw4_unexpected_out", if4.out_data, 32'hFFFF_FFFF);
            else begin
                e0 = q0.pop_front();
                check("fw4_data", if4.out_data, e0.data);
                check("fw4_last", if4.out_last, e0.last);
            end
        end
        if (if4.done) done0++;
    end

    always @(negedge clk) begin
        if (if3.out_valid && if3.out_ready) begin
            if (q1.size() == 0) check("fw3_unexpected_out", if3.out_data, 32'hFFFF_FFFF);
            else begin
                e1 = q1.pop_front();
                check("fw3_data", if3.out_data, e1.data);
                check("fw3_last", if3.out_last, e1.last);
            end
        end
        if (if3.done) done1++;
    end

    always @(negedge clk) begin
        if (if2.out_valid && if2.out_ready) begin
            if (q2.size() == 0) check("fw2_unexpected_out", if2.out_data, 32'hFFFF_FFFF);
            else begin
                e2 = q2.pop_front();
                check("fw2_data", if2.out_data, e2.data);
                check("fw2_last", if2.out_last, e2.last);
            end
        end
        if (if2.done) done2++;
    end

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return if4.in_ready;
            1:       return if3.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return if4.busy;
            1:       return if3.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return if4.done;
            1:       return if3.done;
            default: return if2.done;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [DATW-1:0] d);
        case (sel)
            0:       begin if4.in_valid = v; if4.in_data = d; end
            1:       begin if3.in_valid = v; if3.in_data = d; end
            default: begin if2.in_valid = v; if2.in_data = d; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic s);
        case (sel)
            0:       if4.start = s;
            1:       if3.start = s;
            default: if2.start = s;
        endcase
    endtask

    task automatic set_oready(input int sel, input logic r);
        case (sel)
            0:       if4.out_ready = r;
            1:       if3.out_ready = r;
            default: if2.out_ready = r;
        endcase
    endtask

    task automatic push_exp(input int sel, input exp_t e);
        case (sel)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic logic gt(input logic [DATW-1:0] a, input logic [DATW-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Reference model: max over each full 2x2 window of stim, row-major.
    task automatic push_frame(input int sel, input int fw);
        int hw;
        logic [DATW-1:0] m, v;
        exp_t e;
        hw = fw / 2;
        for (int r = 0; r < hw; r++) begin
            for (int c = 0; c < hw; c++) begin
                m = stim[2 * r * fw + 2 * c];
                for (int k = 1; k < 4; k++) begin
                    v = stim[(2 * r + k / 2) * fw + 2 * c + k % 2];
                    if (gt(v, m)) m = v;
                end
                e.data = m;
                e.last = (r == hw - 1) && (c == hw - 1);
                push_exp(sel, e);
            end
        end
    endtask

    task automatic start_pulse(input int sel);
        @(posedge clk); #1;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
    endtask

    task automatic send(input int sel, input logic [DATW-1:0] d, output int stalls);
        stalls = 0;
        drive(sel, 1'b1, d);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy(sel)) break;
            stalls++;
        end
        if (stalls >= 300) check("send_timeout", rdy(sel), 1);
        @(posedge clk); #1;
        drive(sel, 1'b0, '0);
    endtask

    task automatic send_range(input int sel, input int lo, input int hi, input bit no_stall);
        int st;
        for (int i = lo; i <= hi; i++) begin
            send(sel, stim[i], st);
            if (no_stall) check($sformatf("stall_%0d_%0d", sel, i), st, 0);
        end
    endtask

    task automatic wait_done(input int sel, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_of(sel)) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, found, 1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done_of(sel), 0);
        check({tag, "_busy_after"}, busy_of(sel), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  if4.in_ready, 0);
        check({tag, "_out_valid"}, if4.out_valid, 0);
        check({tag, "_out_data"},  if4.out_data, 0);
        check({tag, "_out_last"},  if4.out_last, 0);
        check({tag, "_busy"},      if4.busy, 0);
        check({tag, "_done"},      if4.done, 0);
    endtask

    task automatic load_ramp(input int n);
        stim.delete();
        for (int i = 1; i <= n; i++) stim.push_back(DATW'(i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   exp_done0;
        exp_done0 = 0;
        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, '0);
            set_start(s, 1'b0);
            set_oready(s, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", if4.in_ready, 0);

        // FW=4 ramp, full throughput
        set_oready(0, 1'b1);
        load_ramp(16);
        push_frame(0, 4);
        start_pulse(0);
        check("fw4_busy_after_start", if4.busy, 1);
        check("fw4_ready_after_start", if4.in_ready, 1);
        send_range(0, 0, 15, 1'b1);
        wait_done(0, "fw4");
        exp_done0++;
        check("fw4_queue_empty", q0.size(), 0);
        check("fw4_done_count", done0, exp_done0);

        // FW=3 floor pooling
        set_oready(1, 1'b1);
        stim.delete();
        stim = '{10'd9, 10'd2, 10'd5, 10'd1, 10'd7, 10'd3, 10'd4, 10'd8, 10'd6};
        push_frame(1, 3);
        start_pulse(1);
        send_range(1, 0, 8, 1'b1);
        wait_done(1, "fw3");
        check("fw3_queue_empty", q1.size(), 0);
        check("fw3_done_count", done1, 1);

        // FW=4 with output back-pressure
        set_oready(0, 1'b0);
        load_ramp(16);
        push_frame(0, 4);
        start_pulse(0);
        fork
            send_range(0, 0, 15, 1'b0);
            begin
                repeat (25) @(negedge clk);
                check("bp_out_valid", if4.out_valid, 1);
                check("bp_in_ready", if4.in_ready, 0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_hold_data", if4.out_data, 6);
                    check("bp_hold_last", if4.out_last, 0);
                end
                @(posedge clk); #1;
                set_oready(0, 1'b1);
            end
        join
        wait_done(0, "bp");
        exp_done0++;
        check("bp_queue_empty", q0.size(), 0);

        // FW=2 ordering of comparison
        set_oready(2, 1'b1);
        stim.delete();
        stim = '{10'h3FF, 10'h3FE, 10'h001, 10'h000};
`ifdef MAXPOOL_SIGNED_EN
        e.data = 10'h001;
`else
        e.data = 10'h3FF;
`endif
        e.last = 1'b1;
        push_exp(2, e);
        start_pulse(2);
        send_range(2, 0, 3, 1'b1);
        wait_done(2, "fw2");
        check("fw2_queue_empty", q2.size(), 0);

        // Reset in the middle of a FW=4 frame
        set_oready(0, 1'b1);
        load_ramp(16);
        e.data = 10'd6;
        e.last = 1'b0;
        push_exp(0, e);
        start_pulse(0);
        send_range(0, 0, 6, 1'b0);
        check("mid_out_data_before", if4.out_data, 6);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        check("mid_queue_empty", q0.size(), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("mid_done_count", done0, exp_done0);
        push_frame(0, 4);
        start_pulse(0);
        send_range(0, 0, 15, 1'b0);
        wait_done(0, "post_reset");
        exp_done0++;
        check("post_reset_queue_empty", q0.size(), 0);

        // start pulses inside RECV and DRAIN are ignored
        push_frame(0, 4);
        start_pulse(0);
        send_range(0, 0, 2, 1'b0);
        start_pulse(0);
        check("recv_start_busy", if4.busy, 1);
        send_range(0, 3, 14, 1'b0);
        set_oready(0, 1'b0);
        send_range(0, 15, 15, 1'b0);
        start_pulse(0);
        check("drain_start_busy", if4.busy, 1);
        check("drain_pending_valid", if4.out_valid, 1);
        check("drain_pending_data", if4.out_data, 16);
        check("drain_no_done", if4.done, 0);
        @(posedge clk); #1;
        set_oready(0, 1'b1);
        wait_done(0, "ign");
        exp_done0++;
        repeat (6) @(negedge clk);
        check("ign_stays_idle", if4.busy, 0);
        check("ign_done_count", done0, exp_done0);
        check("ign_queue_empty", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
